// File: rtl/regfile_pkg.sv
// Shared definitions for the general-purpose register bank and its dump sequencer.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_N_READ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready dump channel between the register bank and the debug unit.
interface regfile_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              start;
  logic              ready;
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;

  modport master (
    output start, ready,
    input  valid, addr, data, busy, done
  );

  modport slave (
    input  start, ready,
    output valid, addr, data, busy, done
  );

endinterface

// File: rtl/regfile_dump_seq.sv
// Dump sequencer: walks the bank one word at a time over a valid/ready channel,
// snapshotting each word at the moment it is loaded for presentation.
module regfile_dump_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_dump_if.slave     dump,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  dump_state_e       state_q, state_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              load;
  logic              accept;

  assign accept = valid_q && dump.ready;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    load    = 1'b0;
    rd_addr = addr_q;
    unique case (state_q)
      IDLE: begin
        if (dump.start) begin
          load    = 1'b1;
          rd_addr = '0;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (addr_q == LAST_ADDR) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else begin
            load    = 1'b1;
            rd_addr = addr_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (load) begin
        addr_q <= rd_addr;
        data_q <= rd_data;
      end
    end
  end

  assign dump.valid = valid_q;
  assign dump.addr  = addr_q;
  assign dump.data  = data_q;
  assign dump.busy  = (state_q != IDLE);
  assign dump.done  = (state_q == DONE);

endmodule

// File: rtl/regfile_bank.sv
// Parametrised multi-read-port register file with write-first bypass, optional
// hardwired-zero register 0 and a handshaked full-bank dump port.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_READ   = RF_N_READ,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     i_reset_n,
  input  logic                     i_wenable,
  input  logic [ADDR_W-1:0]        i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [N_READ*ADDR_W-1:0] i_raddr,
  output logic [N_READ*DATA_W-1:0] o_rdata,
  regfile_dump_if.slave            dump
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] dump_rd_addr;
  logic [DATA_W-1:0] dump_rd_data;
  logic              write_ok;

  assign write_ok = i_wenable && !((ZERO_REG != 0) && (i_waddr == '0));

  // Write-first view of one register; address 0 is forced to zero and never bypassed.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if ((ZERO_REG != 0) && (addr == '0)) return '0;
    if (wen && (waddr == addr))          return wdata;
    return stored;
  endfunction

  // NOTE: the array is cleared on reset, so it maps to flops rather than RAM;
  // the bank is small and the clear is part of its contract.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (write_ok) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  for (genvar k = 0; k < N_READ; k++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] q;

    assign addr = i_raddr[k*ADDR_W +: ADDR_W];

    always_ff @(posedge clk) begin
      if (!i_reset_n) q <= '0;
      else            q <= read_mux(addr, mem[addr], i_wenable, i_waddr, i_wdata);
    end

    assign o_rdata[k*DATA_W +: DATA_W] = q;
  end

  assign dump_rd_data = read_mux(dump_rd_addr, mem[dump_rd_addr], i_wenable, i_waddr, i_wdata);

  regfile_dump_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dump_seq (
    .clk     (clk),
    .rst_n   (i_reset_n),
    .dump    (dump),
    .rd_addr (dump_rd_addr),
    .rd_data (dump_rd_data)
  );

endmodule
